// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute with per-opcode memory and
// write-back phases, memory-ready timeout, halt state and retired-instruction count.
//
// state       | meaning
// IDLE        | waiting for Start after reset
// FETCH       | instruction fetch, waits on MemReady
// DECODE      | latch opcode, branch to EXEC or HALT
// EXEC        | one-cycle execute, routes on opcode masks
// MEM_WAIT    | data access, waits on MemReady
// WRITEBACK   | one-cycle register write
// HALT        | stopped (halt opcode or timeout), waits on Start
module control_sequencer #(
  parameter int                            OPCODE_WIDTH   = 3,
  parameter logic [2**OPCODE_WIDTH-1:0]    MEM_MASK       = 8'b0000_0110,
  parameter logic [2**OPCODE_WIDTH-1:0]    WB_MASK        = 8'b0011_1101,
  parameter logic [OPCODE_WIDTH-1:0]       HALT_OPCODE    = 3'b111,
  parameter int                            TIMEOUT_CYCLES = 8,
  parameter int                            COUNT_WIDTH    = 8
) (
  input  logic                      Clock,
  input  logic                      Clear,
  input  logic                      Start,
  input  logic [OPCODE_WIDTH-1:0]   OPCODE,
  input  logic                      MemReady,
  output logic [OPCODE_WIDTH+1:0]   Output,
  output logic [OPCODE_WIDTH-1:0]   CurOpcode,
  output logic                      Busy,
  output logic                      Halted,
  output logic                      Error,
  output logic [COUNT_WIDTH-1:0]    InstrCount
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM_WAIT, S_WRITEBACK, S_HALT
  } state_t;

  state_t                    state, state_next;
  logic [TMO_W-1:0]          tmo_cnt, tmo_next;
  logic [OPCODE_WIDTH-1:0]   cur_next;
  logic [OPCODE_WIDTH+1:0]   code_next;
  logic                      err_next;
  logic                      busy_next;
  logic                      retire;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state      <= S_IDLE;
      tmo_cnt    <= '0;
      Output     <= '0;
      CurOpcode  <= '0;
      Busy       <= 1'b0;
      Halted     <= 1'b0;
      Error      <= 1'b0;
      InstrCount <= '0;
    end else begin
      state      <= state_next;
      tmo_cnt    <= tmo_next;
      Output     <= code_next;
      CurOpcode  <= cur_next;
      Busy       <= busy_next;
      Halted     <= (state_next == S_HALT);
      Error      <= err_next;
      InstrCount <= InstrCount + COUNT_WIDTH'(retire);
    end
  end

  always_comb begin
    state_next = state;
    cur_next   = CurOpcode;
    tmo_next   = '0;
    err_next   = Error;
    retire     = 1'b0;
    case (state)
      S_IDLE: if (Start) state_next = S_FETCH;
      S_FETCH: begin
        if (MemReady) state_next = S_DECODE;
        else if (tmo_cnt == TMO_LAST) begin
          state_next = S_HALT;
          err_next   = 1'b1;
        end else tmo_next = tmo_cnt + 1'b1;
      end
      S_DECODE: begin
        cur_next   = OPCODE;
        state_next = (OPCODE == HALT_OPCODE) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (MEM_MASK[CurOpcode])     state_next = S_MEM_WAIT;
        else if (WB_MASK[CurOpcode]) state_next = S_WRITEBACK;
        else begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (MemReady) begin
          if (WB_MASK[CurOpcode]) state_next = S_WRITEBACK;
          else begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = S_HALT;
          err_next   = 1'b1;
        end else tmo_next = tmo_cnt + 1'b1;
      end
      S_WRITEBACK: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT: begin
        if (Start) begin
          state_next = S_FETCH;
          err_next   = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Output code is built from the next state so it lands in the same edge as the state
    case (state_next)
      S_FETCH:     code_next = {2'b10, {OPCODE_WIDTH{1'b0}}};
      S_DECODE:    code_next = {2'b11, {OPCODE_WIDTH{1'b0}}};
      S_EXEC:      code_next = {2'b01, cur_next};
      S_MEM_WAIT:  code_next = {2'b11, OPCODE_WIDTH'(1)};
      S_WRITEBACK: code_next = {2'b11, OPCODE_WIDTH'(2)};
      S_HALT:      code_next = {2'b11, {OPCODE_WIDTH{1'b1}}};
      default:     code_next = '0;
    endcase
    busy_next = !((state_next == S_IDLE) || (state_next == S_HALT));
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed literal sequences plus randomized traffic,
// all outputs compared every cycle against an instruction-level model.
module tb_control_sequencer;

  localparam int OW  = 3;
  localparam int TMO = 8;
  localparam logic [7:0] MEM_M = 8'b0000_0110;
  localparam logic [7:0] WB_M  = 8'b0011_1101;
  localparam int HALT_OP = 7;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3,
                 P_MEM = 4, P_WB = 5, P_HALT = 6;

  logic       Clock = 1'b0;
  logic       Clear = 1'b0;
  logic       Start = 1'b0;
  logic       MemReady = 1'b0;
  logic [2:0] OPCODE = 3'd0;
  logic [4:0] Output;
  logic [2:0] CurOpcode;
  logic       Busy, Halted, Error;
  logic [7:0] InstrCount;

  int n_checks = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  int m_phase, m_op, m_wait, m_cnt;
  bit m_err;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .OPCODE(OPCODE),
    .MemReady(MemReady), .Output(Output), .CurOpcode(CurOpcode),
    .Busy(Busy), .Halted(Halted), .Error(Error), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic m_reset();
    m_phase = P_IDLE; m_op = 0; m_wait = 0; m_cnt = 0; m_err = 1'b0;
  endtask

  task automatic m_retire();
    m_cnt++;
    m_phase = P_FETCH;
    m_wait = 0;
  endtask

  task automatic m_not_ready();
    m_wait++;
    if (m_wait >= TMO) begin
      m_phase = P_HALT;
      m_err = 1'b1;
    end
  endtask

  task automatic m_step();
    case (m_phase)
      P_IDLE: if (Start) begin m_phase = P_FETCH; m_wait = 0; end
      P_FETCH: if (MemReady) m_phase = P_DECODE; else m_not_ready();
      P_DECODE: begin
        m_op = int'(OPCODE);
        m_phase = (m_op == HALT_OP) ? P_HALT : P_EXEC;
      end
      P_EXEC: begin
        if (MEM_M[m_op]) begin m_phase = P_MEM; m_wait = 0; end
        else if (WB_M[m_op]) m_phase = P_WB;
        else m_retire();
      end
      P_MEM: begin
        if (MemReady) begin
          if (WB_M[m_op]) m_phase = P_WB;
          else m_retire();
        end else m_not_ready();
      end
      P_WB: m_retire();
      default: if (Start) begin m_phase = P_FETCH; m_err = 1'b0; m_wait = 0; end
    endcase
  endtask

  function automatic logic [31:0] exp_code();
    int c;
    case (m_phase)
      P_FETCH:  c = 2 << OW;
      P_DECODE: c = 3 << OW;
      P_EXEC:   c = (1 << OW) + m_op;
      P_MEM:    c = (3 << OW) + 1;
      P_WB:     c = (3 << OW) + 2;
      P_HALT:   c = (3 << OW) + (2 ** OW - 1);
      default:  c = 0;
    endcase
    return 32'(c);
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge Clock or posedge Clear);
      if (Clear) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(negedge Clock);
    if (cmp_en) begin
      chk("model_output", 32'(Output), exp_code());
      chk("model_curopcode", 32'(CurOpcode), 32'(m_op));
      chk("model_busy", 32'(Busy), 32'(m_phase != P_IDLE && m_phase != P_HALT));
      chk("model_halted", 32'(Halted), 32'(m_phase == P_HALT));
      chk("model_error", 32'(Error), 32'(m_err));
      chk("model_count", 32'(InstrCount), 32'(m_cnt % 256));
    end
  end

  task automatic nxt();
    @(negedge Clock);
  endtask

  initial begin
    #1 Clear = 1'b1;
    #2;
    chk("rst_output", 32'(Output), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);
    chk("rst_count", 32'(InstrCount), 32'd0);
    chk("rst_curop", 32'(CurOpcode), 32'd0);
    nxt();
    Clear = 1'b0; cmp_en = 1'b1;

    // opcode 3: fetch, decode, exec, writeback
    Start = 1'b1; MemReady = 1'b1; OPCODE = 3'd3;
    nxt(); chk("t1_fetch", 32'(Output), 32'b10000); chk("t1_busy", 32'(Busy), 32'd1);
    Start = 1'b0;
    nxt(); chk("t1_decode", 32'(Output), 32'b11000);
    nxt(); chk("t1_exec", 32'(Output), 32'b01011);
    nxt(); chk("t1_wb", 32'(Output), 32'b11010);
    nxt(); chk("t1_refetch", 32'(Output), 32'b10000); chk("t1_count", 32'(InstrCount), 32'd1);

    // load with three not-ready cycles in MEM_WAIT
    OPCODE = 3'd2;
    nxt(); chk("t2_decode", 32'(Output), 32'b11000);
    nxt(); chk("t2_exec", 32'(Output), 32'b01010);
    MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt(); chk("t2_memwait", 32'(Output), 32'b11001);
    end
    MemReady = 1'b1;
    nxt(); chk("t2_wb", 32'(Output), 32'b11010);
    nxt(); chk("t2_fetch", 32'(Output), 32'b10000);
    chk("t2_error", 32'(Error), 32'd0); chk("t2_count", 32'(InstrCount), 32'd2);

    // opcode 1 skips writeback, opcode 6 goes straight back to fetch
    OPCODE = 3'd1;
    nxt(); nxt(); chk("t3_exec1", 32'(Output), 32'b01001);
    nxt(); chk("t3_mem1", 32'(Output), 32'b11001);
    nxt(); chk("t3_fetch1", 32'(Output), 32'b10000);
    OPCODE = 3'd6;
    nxt(); nxt(); chk("t3_exec6", 32'(Output), 32'b01110);
    nxt(); chk("t3_fetch6", 32'(Output), 32'b10000); chk("t3_count", 32'(InstrCount), 32'd4);

    // memory timeout
    OPCODE = 3'd2;
    nxt(); nxt(); MemReady = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      nxt(); chk("t4_memwait", 32'(Output), 32'b11001);
    end
    nxt();
    chk("t4_halt", 32'(Output), 32'b11111); chk("t4_halted", 32'(Halted), 32'd1);
    chk("t4_error", 32'(Error), 32'd1); chk("t4_busy", 32'(Busy), 32'd0);
    chk("t4_count", 32'(InstrCount), 32'd4);
    Start = 1'b1; MemReady = 1'b1;
    nxt(); chk("t4_restart", 32'(Output), 32'b10000); chk("t4_errclr", 32'(Error), 32'd0);
    Start = 1'b0;

    // ready arrives in the last allowed cycle
    nxt(); nxt(); MemReady = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      nxt();
      if (i == TMO - 1) MemReady = 1'b1;
    end
    nxt(); chk("t4b_wb", 32'(Output), 32'b11010); chk("t4b_error", 32'(Error), 32'd0);
    nxt(); chk("t4b_count", 32'(InstrCount), 32'd5);

    // halt opcode
    OPCODE = 3'd7;
    nxt(); nxt(); chk("t5_halt", 32'(Output), 32'b11111);
    chk("t5_curop", 32'(CurOpcode), 32'd7); chk("t5_count", 32'(InstrCount), 32'd5);
    for (int i = 0; i < 10; i++) begin
      MemReady = 1'($urandom_range(0, 1));
      nxt(); chk("t5_hold", 32'(Output), 32'b11111);
    end
    Start = 1'b1; MemReady = 1'b1;
    nxt(); chk("t5_restart", 32'(Output), 32'b10000);
    Start = 1'b0;

    // asynchronous Clear in the middle of MEM_WAIT
    OPCODE = 3'd2;
    nxt(); nxt(); MemReady = 1'b0;
    nxt(); chk("t6_memwait", 32'(Output), 32'b11001);
    #1 Clear = 1'b1;
    #1;
    chk("t6_output", 32'(Output), 32'd0); chk("t6_curop", 32'(CurOpcode), 32'd0);
    chk("t6_busy", 32'(Busy), 32'd0); chk("t6_count", 32'(InstrCount), 32'd0);
    nxt(); Clear = 1'b0; MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt(); chk("t6_idle", 32'(Output), 32'd0);
    end
    Start = 1'b1;
    nxt(); chk("t6_fetch", 32'(Output), 32'b10000);
    Start = 1'b0;

    // counter wrap over 256 retirements
    for (int i = 0; i < 3000 && m_cnt < 255; i++) begin
      OPCODE = 3'($urandom_range(0, 6));
      nxt();
    end
    chk("t7_count255", 32'(InstrCount), 32'd255);
    for (int i = 0; i < 20 && m_cnt < 256; i++) begin
      OPCODE = 3'($urandom_range(0, 6));
      nxt();
    end
    chk("t7_wrap", 32'(InstrCount), 32'd0);

    // randomized traffic, alternating healthy and starved memory
    for (int i = 0; i < 4000; i++) begin
      Start    = ($urandom_range(0, 3) == 0);
      MemReady = (((i / 200) % 2) == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) < 3);
      OPCODE   = 3'($urandom_range(0, 7));
      Clear    = ($urandom_range(0, 299) == 0);
      nxt();
    end
    Clear = 1'b0;
    nxt();
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
